// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: the XZR index,
// the default FIFO depth and the queued-result entry layout.
package regfile_write_arbiter_pkg;

  localparam logic [4:0]  XZR           = 5'd31;
  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [63:0] data;
  } rf_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO of multi-cycle results with squash-by-register and
// per-entry destination match outputs for hazard checks.
module wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  rf_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   squash_en,
  input  logic [4:0]             squash_reg,
  input  logic [4:0]             match_reg1,
  input  logic [4:0]             match_reg2,
  output rf_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       match1,
  output logic [DEPTH-1:0]       match2
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rf_entry_t     mem_q [DEPTH];
  rf_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Squash first, then pop/push: a same-cycle push lands on the tail slot
  // after the squash, so the younger mc result survives.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (squash_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_q[i].valid && (mem_q[i].rd == squash_reg)) begin
          mem_d[i].valid = 1'b0;
        end
      end
    end
    if (pop) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match1[i] = mem_q[i].valid && (mem_q[i].rd == match_reg1);
      match2[i] = mem_q[i].valid && (mem_q[i].rd == match_reg2);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter: pipeline writebacks take priority, multi-cycle
// results queue in a FIFO and drain in idle cycles; XZR writes are dropped.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg,
  input  logic [63:0]            wb_data,
  input  logic                   mc_valid,
  input  logic [4:0]             mc_reg,
  input  logic [63:0]            mc_data,
  output logic                   mc_ready,
  output logic                   RegWrite,
  output logic [4:0]             WriteRegister,
  output logic [63:0]            WriteData,
  input  logic [4:0]             chk_reg1,
  input  logic [4:0]             chk_reg2,
  output logic                   pending1,
  output logic                   pending2,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             wb_fire;
  logic             mc_push;
  logic             drain;
  rf_entry_t        push_entry;
  rf_entry_t        head;
  logic [DEPTH-1:0] match1, match2;

  logic             regwrite_q, regwrite_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [63:0]      wdata_q, wdata_d;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (mc_push),
    .push_entry (push_entry),
    .pop        (drain),
    .squash_en  (wb_fire),
    .squash_reg (wb_reg),
    .match_reg1 (chk_reg1),
    .match_reg2 (chk_reg2),
    .head       (head),
    .count      (fifo_count),
    .match1     (match1),
    .match2     (match2)
  );

  // Any wb_valid, even a dropped XZR write, holds off the drain.
  always_comb begin
    wb_fire    = wb_valid && (wb_reg != XZR);
    mc_ready   = (fifo_count < CW'(DEPTH));
    mc_push    = mc_valid && mc_ready && (mc_reg != XZR);
    drain      = !wb_valid && (fifo_count != '0);
    push_entry = {1'b1, mc_reg, mc_data};

    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (wb_fire) begin
      regwrite_d = 1'b1;
      wreg_d     = wb_reg;
      wdata_d    = wb_data;
    end else if (drain && head.valid) begin
      regwrite_d = 1'b1;
      wreg_d     = head.rd;
      wdata_d    = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    pending1 = (chk_reg1 != XZR) && ((|match1) || (regwrite_q && (wreg_q == chk_reg1)));
    pending2 = (chk_reg2 != XZR) && ((|match2) || (regwrite_q && (wreg_q == chk_reg2)));
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then randomized
// traffic compared against a queue-based reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_reg;
  logic [63:0] mc_data;
  logic        mc_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  chk_reg1, chk_reg2;
  logic        pending1, pending2;
  logic [2:0]  fifo_count;

  regfile_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .pending1(pending1), .pending2(pending2), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_rw, input logic [4:0] e_wr,
                           input logic [63:0] e_wd, input logic e_rdy, input logic [2:0] e_cnt,
                           input logic e_p1, input logic e_p2);
    chk({tag, ".RegWrite"},      64'(RegWrite),      64'(e_rw));
    chk({tag, ".WriteRegister"}, 64'(WriteRegister), 64'(e_wr));
    chk({tag, ".WriteData"},     WriteData,          e_wd);
    chk({tag, ".mc_ready"},      64'(mc_ready),      64'(e_rdy));
    chk({tag, ".fifo_count"},    64'(fifo_count),    64'(e_cnt));
    chk({tag, ".pending1"},      64'(pending1),      64'(e_p1));
    chk({tag, ".pending2"},      64'(pending2),      64'(e_p2));
  endtask

  // Directed vectors: inputs for a cycle and the outputs expected during it.
  typedef struct {
    logic rst; logic wbv; logic [4:0] wbr; logic [63:0] wbd;
    logic mcv; logic [4:0] mcr; logic [63:0] mcd;
    logic [4:0] c1; logic [4:0] c2;
    logic erw; logic [4:0] ewr; logic [63:0] ewd;
    logic erdy; logic [2:0] ecnt; logic ep1; logic ep2;
  } vec_t;

  function automatic vec_t mk(int rst, int wbv, int wbr, longint wbd, int mcv, int mcr, longint mcd,
                              int c1, int c2, int erw, int ewr, longint ewd,
                              int erdy, int ecnt, int ep1, int ep2);
    vec_t v;
    v.rst = 1'(rst); v.wbv = 1'(wbv); v.wbr = 5'(wbr); v.wbd = 64'(wbd);
    v.mcv = 1'(mcv); v.mcr = 5'(mcr); v.mcd = 64'(mcd);
    v.c1 = 5'(c1); v.c2 = 5'(c2);
    v.erw = 1'(erw); v.ewr = 5'(ewr); v.ewd = 64'(ewd);
    v.erdy = 1'(erdy); v.ecnt = 3'(ecnt); v.ep1 = 1'(ep1); v.ep2 = 1'(ep2);
    return v;
  endfunction

  vec_t tv[$];

  // Reference model: a queue of pending results plus the output register.
  typedef struct { bit v; logic [4:0] r; logic [63:0] d; } ment_t;
  ment_t       mq[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [63:0] m_wd = '0;

  function automatic logic m_pending(input logic [4:0] c);
    if (c == 5'd31) return 1'b0;
    if (m_rw && (m_wr == c)) return 1'b1;
    foreach (mq[i]) if (mq[i].v && (mq[i].r == c)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit    rdy;
    ment_t e;
    rdy = (mq.size() < 4);
    if (reset) begin
      mq.delete();
      m_rw = 1'b0; m_wr = '0; m_wd = '0;
      return;
    end
    m_rw = 1'b0;
    if (wb_valid) begin
      if (wb_reg != 5'd31) begin
        m_rw = 1'b1; m_wr = wb_reg; m_wd = wb_data;
        foreach (mq[i]) if (mq[i].r == wb_reg) mq[i].v = 1'b0;
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.v) begin
        m_rw = 1'b1; m_wr = e.r; m_wd = e.d;
      end
    end
    if (mc_valid && rdy && (mc_reg != 5'd31)) mq.push_back('{1'b1, mc_reg, mc_data});
  endtask

  function automatic logic [4:0] rnd_reg();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 8) return 5'(r);
    if (r < 10) return 5'd31;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    bit hold;
    reset = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0; chk_reg1 = '0; chk_reg2 = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    check_all("reset", 1'b0, 5'd0, 64'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      chk_reg1 = 5'(c); chk_reg2 = 5'(31 - c);
      #1;
      chk($sformatf("reset.pending1[%0d]", c), 64'(pending1), 64'd0);
      chk($sformatf("reset.pending2[%0d]", 31 - c), 64'(pending2), 64'd0);
      @(posedge clk); #1;
    end

    //           rst wb r  d      mc r  d       c1 c2  rw wr wd     rdy cnt p1 p2
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      5, 0,  0, 0, 0,     1,0, 0,0));
    tv.push_back(mk(0, 1,5, 'hAA,  0,0, 0,      5, 3,  0, 0, 0,     1,0, 0,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      5, 0,  1, 5, 'hAA,  1,0, 1,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      5,31,  0, 5, 'hAA,  1,0, 0,0));
    tv.push_back(mk(0, 1,7, 'h77,  1,3, 'h11,   3, 7,  0, 5, 'hAA,  1,0, 0,0));
    tv.push_back(mk(0, 1,7, 'h78,  0,0, 0,      3, 7,  1, 7, 'h77,  1,1, 1,1));
    tv.push_back(mk(0, 1,7, 'h79,  0,0, 0,      3, 7,  1, 7, 'h78,  1,1, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      3, 7,  1, 7, 'h79,  1,1, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      3, 7,  1, 3, 'h11,  1,0, 1,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      3, 7,  0, 3, 'h11,  1,0, 0,0));
    tv.push_back(mk(0, 0,0, 0,     1,9, 'h1,    9, 0,  0, 3, 'h11,  1,0, 0,0));
    tv.push_back(mk(0, 1,9, 'h2,   0,0, 0,      9, 0,  0, 3, 'h11,  1,1, 1,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      9, 0,  1, 9, 'h2,   1,1, 1,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      9, 0,  0, 9, 'h2,   1,0, 0,0));
    tv.push_back(mk(0, 1,31,'h55,  1,31,'h66,  31,31,  0, 9, 'h2,   1,0, 0,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,     31, 9,  0, 9, 'h2,   1,0, 0,0));
    tv.push_back(mk(0, 1,20,'h20,  1,1, 'h101,  1, 4,  0, 9, 'h2,   1,0, 0,0));
    tv.push_back(mk(0, 1,20,'h20,  1,2, 'h102,  1, 4,  1,20, 'h20,  1,1, 1,0));
    tv.push_back(mk(0, 1,20,'h20,  1,3, 'h103,  1, 4,  1,20, 'h20,  1,2, 1,0));
    tv.push_back(mk(0, 1,20,'h20,  1,4, 'h104,  1, 4,  1,20, 'h20,  1,3, 1,0));
    tv.push_back(mk(0, 1,20,'h20,  1,5, 'h105,  1, 4,  1,20, 'h20,  0,4, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  1,20, 'h20,  0,4, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  1, 1, 'h101, 1,3, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  1, 2, 'h102, 1,2, 0,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  1, 3, 'h103, 1,1, 0,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  1, 4, 'h104, 1,0, 0,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      1, 4,  0, 4, 'h104, 1,0, 0,0));
    tv.push_back(mk(0, 1,20,'h20,  1,6, 'h106,  6, 7,  0, 4, 'h104, 1,0, 0,0));
    tv.push_back(mk(0, 1,20,'h20,  1,7, 'h107,  6, 7,  1,20, 'h20,  1,1, 1,0));
    tv.push_back(mk(0, 1,20,'h20,  1,8, 'h108,  6, 7,  1,20, 'h20,  1,2, 1,1));
    tv.push_back(mk(1, 0,0, 0,     0,0, 0,      6, 8,  1,20, 'h20,  1,3, 1,1));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      6, 8,  0, 0, 0,     1,0, 0,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      7, 8,  0, 0, 0,     1,0, 0,0));
    tv.push_back(mk(0, 0,0, 0,     0,0, 0,      7, 8,  0, 0, 0,     1,0, 0,0));

    foreach (tv[i]) begin
      reset = tv[i].rst; wb_valid = tv[i].wbv; wb_reg = tv[i].wbr; wb_data = tv[i].wbd;
      mc_valid = tv[i].mcv; mc_reg = tv[i].mcr; mc_data = tv[i].mcd;
      chk_reg1 = tv[i].c1; chk_reg2 = tv[i].c2;
      #1;
      check_all($sformatf("row%0d", i), tv[i].erw, tv[i].ewr, tv[i].ewd,
                tv[i].erdy, tv[i].ecnt, tv[i].ep1, tv[i].ep2);
      @(posedge clk); #1;
    end

    // Randomized traffic; mc holds its offer stable while backpressured.
    hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset    = (cyc == 0) || ($urandom_range(0, 249) == 0);
      wb_valid = ($urandom_range(0, 99) < 50);
      wb_reg   = rnd_reg();
      wb_data  = {$urandom(), $urandom()};
      if (!hold) begin
        mc_valid = ($urandom_range(0, 99) < 40);
        mc_reg   = rnd_reg();
        mc_data  = {$urandom(), $urandom()};
      end
      chk_reg1 = rnd_reg();
      chk_reg2 = rnd_reg();
      #1;
      check_all($sformatf("rnd%0d", cyc), m_rw, m_wr, m_wd, 1'(mq.size() < 4),
                3'(mq.size()), m_pending(chk_reg1), m_pending(chk_reg2));
      hold = mc_valid && (mq.size() >= 4) && !reset;
      model_edge();
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Single-writer front end for the 32×64 register file's one write port. It merges same-cycle writebacks from the main pipeline with out-of-order results from the multi-cycle multiply/divide unit, and buffers the latter in a 4-entry FIFO. It drives the register file's RegWrite/WriteRegister/WriteData inputs and reports pending-write status to the hazard unit.

## Interface
- DEPTH, 4, multi-cycle result FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline writeback request this cycle
- wb_reg  in  5  pipeline destination register
- wb_data  in  64  pipeline result
- mc_valid  in  1  multi-cycle unit result offered
- mc_reg  in  5  multi-cycle destination register
- mc_data  in  64  multi-cycle result
- mc_ready  out  1  FIFO can accept; transfer when mc_valid & mc_ready
- RegWrite  out  1  register-file write enable (registered)
- WriteRegister  out  5  register-file write index (registered)
- WriteData  out  64  register-file write data (registered)
- chk_reg1, chk_reg2  in  5 each  source registers to check for pending writes
- pending1, pending2  out  1 each  write to chk_regN is queued or in flight
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Priority: a pipeline write always wins the port. The FIFO head drains only in cycles with no wb_valid.
- Register 31 (XZR): writes to 31 from either source are dropped. They are never enqueued and never raise RegWrite. Pending flags for 31 are always 0.
- Enqueue: an accepted mc transfer is written at the tail. mc_ready = (count < DEPTH), computed combinationally from the current count only. It does not depend on a same-cycle dequeue.
- Simultaneous enqueue and dequeue: count is unchanged and both the head and tail pointers advance.
- Squash: when a pipeline write to reg R (R≠31) is accepted, every valid FIFO entry targeting R is invalidated, because the younger pipeline write wins. An mc transfer to R in the same cycle is not squashed, since it is younger.
- Invalidated entries still occupy FIFO slots. When they reach the head they are popped in a drain cycle without asserting RegWrite.
- Output stage: RegWrite/WriteRegister/WriteData are loaded every cycle from the selected source, or RegWrite=0 if there is none. When RegWrite=0, WriteRegister and WriteData hold their previous values.
- pendingN = 1 if chk_regN≠31 and either (a) a valid, unsquashed FIFO entry targets it, or (b) RegWrite=1 with WriteRegister = chk_regN. The check is combinational.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates structurally and never exceeds DEPTH.

## Timing
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, count=0, all entry-valid bits 0, mc_ready=1, pending1/2=0.
- Reset takes effect mid-operation: all queued results are discarded in the same edge.
- Pipeline write latency: wb_valid at cycle n gives RegWrite=1 in cycle n+1. The register file commits at the end of n+1.
- Multi-cycle latency from an empty FIFO with no pipeline traffic: accepted at n, at the head in n+1, drained in n+1, and RegWrite=1 in n+2.
- Starvation: the FIFO may wait indefinitely under continuous wb_valid. This is required behaviour, and the hazard unit stalls as needed.
- Full: while count==DEPTH, mc_ready=0. The mc unit holds mc_valid/reg/data stable until accepted.

## Structure
- Shared package: XZR index constant (5'd31), DEPTH default, and a packed entry typedef {valid, reg[4:0], data[63:0]}.
- One natural sub-module: `wb_fifo`. It is a synchronous FIFO of entry structs with a per-entry squash-by-register port and per-entry match outputs used for the pending checks.
- Top level holds the priority mux, XZR filter, and registered output stage.

## Test plan
- Reset then idle: after reset=1 for 1 cycle, RegWrite=0, mc_ready=1, fifo_count=0, and pending1/2=0 for all chk_reg values.
- Pipeline only: wb_valid, wb_reg=5, wb_data=0xAA at n → RegWrite=1, WriteRegister=5, WriteData=0xAA at n+1. pending for reg 5 is 1 in n+1 and 0 in n+2.
- Contention: mc writes to X3=0x11 accepted at n, with wb_valid to X7 held for cycles n..n+2 → X7 written n+1..n+3, X3 written at n+4. pending(3)=1 from n+1 through n+4.
- Full/backpressure: 4 mc transfers (X1..X4) under continuous wb_valid → mc_ready=0 and fifo_count=4. After wb_valid drops, writes to X1, X2, X3, X4 follow in order on consecutive cycles.
- Squash: mc to X9=0x1 queued, then wb to X9=0x2 → only 0x2 reaches the register file. The stale entry pops with RegWrite=0, and pending(9)=0 once the wb write retires.
- XZR and reset mid-operation: wb_reg=31 and mc_reg=31 produce no RegWrite and no enqueue. reset with 3 entries queued gives count=0 and no further writes.
